prog_loader: RTL

//  UART program loader: the writer side of the TinyBF program store. Receives a framed

---
 rtl/prog_loader.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Writer side of the TinyBF program store. Receives a framed Brainfuck image
//   from uart_rx, writes it into program RAM, holds the CPU off while a frame
//   is in progress and replies ACK/NAK through uart_tx.
//
//   Frame: SYNC_BYTE, LEN, LEN data bytes, CHK (mod-256 sum of the data bytes).
//   LEN must be 1..DEPTH. Data bytes are written as they arrive, so a NAKed
//   frame can leave the RAM partially updated.
//
//   Optional feature (macro PROG_LOADER_TIMEOUT_EN): inter-byte timeout inside a
//   frame. When the macro is absent the loader waits in a frame indefinitely and
//   the TIMEOUT_CYCLES parameter does not exist.
//
// Ports
//   clk_i          in   system clock
//   rst_i          in   synchronous reset, active-low
//   rx_data_i      in   byte from uart_rx
//   rx_valid_i     in   1-cycle strobe qualifying rx_data_i
//   tx_data_o      out  reply byte to uart_tx (held from reply decision on)
//   tx_start_o     out  1-cycle start pulse to uart_tx
//   tx_busy_i      in   uart_tx busy
//   prog_waddr_o   out  program RAM write address
//   prog_wdata_o   out  program RAM write data
//   prog_wen_o     out  program RAM write enable, 1 cycle per data byte
//   load_active_o  out  frame in progress (CPU held)
//   load_done_o    out  1-cycle pulse when ACK is issued
//   err_o          out  sticky: last frame was NAKed
// -----------------------------------------------------------------------------
module prog_loader #(
   parameter int         ADDR_W    = 4,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter logic [7:0] ACK_BYTE  = 8'h06,
   parameter logic [7:0] NAK_BYTE  = 8'h15
`ifdef PROG_LOADER_TIMEOUT_EN
   ,
   parameter int         TIMEOUT_CYCLES = 500000
`endif
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_start_o,
   input  logic              tx_busy_i,
   output logic [ADDR_W-1:0] prog_waddr_o,
   output logic [7:0]        prog_wdata_o,
   output logic              prog_wen_o,
   output logic              load_active_o,
   output logic              load_done_o,
   output logic              err_o
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CHK,
      S_RESP
   } state_t;

   state_t state_q, state_d;

   // Frame bookkeeping
   logic [7:0]        remain_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        sum_q;
   logic              resp_ack_q;

   // Registered RAM write port (one cycle behind the rx strobe)
   logic              vld_p1;
   logic [ADDR_W-1:0] waddr_p1;
   logic [7:0]        wdata_p1;

   // Status registers
   logic [7:0]        tx_data_q;
   logic              active_q;
   logic              err_q;

   // FSM decode strobes
   logic sync_take, len_take, data_take, resp_enter, resp_ack_d, resp_fire;
   logic len_bad;
   logic timeout;

   assign len_bad = (rx_data_i == 8'd0) || ({24'd0, rx_data_i} > 32'(DEPTH));

`ifdef PROG_LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             in_frame;

   assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
   assign timeout  = in_frame && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

   // Idle time since the last byte; SYNC accept is itself an rx strobe.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         tmo_cnt_q <= '0;
      end else if (rx_valid_i || !in_frame) begin
         tmo_cnt_q <= '0;
      end else if (!timeout) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // tx_start_o / load_done_o are decoded from RESP so the reply leaves exactly
   // one cycle after the final strobe when uart_tx is idle.
   always_comb begin
      state_d     = state_q;
      tx_start_o  = 1'b0;
      load_done_o = 1'b0;
      sync_take   = 1'b0;
      len_take    = 1'b0;
      data_take   = 1'b0;
      resp_enter  = 1'b0;
      resp_ack_d  = 1'b0;
      resp_fire   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
               sync_take = 1'b1;
               state_d   = S_LEN;
            end
         end
         S_LEN: begin
            if (rx_valid_i) begin
               if (len_bad) begin
                  resp_enter = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  len_take = 1'b1;
                  state_d  = S_DATA;
               end
            end else if (timeout) begin
               resp_enter = 1'b1;
               state_d    = S_RESP;
            end
         end
         S_DATA: begin
            if (rx_valid_i) begin
               data_take = 1'b1;
               if (remain_q == 8'd1) begin
                  state_d = S_CHK;
               end
            end else if (timeout) begin
               resp_enter = 1'b1;
               state_d    = S_RESP;
            end
         end
         S_CHK: begin
            if (rx_valid_i) begin
               resp_enter = 1'b1;
               resp_ack_d = (rx_data_i == sum_q);
               state_d    = S_RESP;
            end else if (timeout) begin
               resp_enter = 1'b1;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            // Incoming bytes are ignored here; no re-sync until back in IDLE.
            if (!tx_busy_i) begin
               tx_start_o  = 1'b1;
               load_done_o = resp_ack_q;
               resp_fire   = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---- stage p0 -> p1: rx strobe to RAM write / frame state ----
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         vld_p1     <= 1'b0;
         waddr_p1   <= '0;
         wdata_p1   <= '0;
         remain_q   <= '0;
         addr_q     <= '0;
         sum_q      <= '0;
         resp_ack_q <= 1'b0;
         tx_data_q  <= '0;
         active_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         vld_p1 <= data_take;
         if (sync_take) begin
            active_q <= 1'b1;
            err_q    <= 1'b0;
         end
         if (len_take) begin
            remain_q <= rx_data_i;
            addr_q   <= '0;
            sum_q    <= '0;
         end
         if (data_take) begin
            waddr_p1 <= addr_q;
            wdata_p1 <= rx_data_i;
            addr_q   <= addr_q + 1'b1;
            sum_q    <= sum_q + rx_data_i;
            remain_q <= remain_q - 8'd1;
         end
         if (resp_enter) begin
            resp_ack_q <= resp_ack_d;
            tx_data_q  <= resp_ack_d ? ACK_BYTE : NAK_BYTE;
         end
         if (resp_fire) begin
            active_q <= 1'b0;
            if (!resp_ack_q) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign prog_wen_o    = vld_p1;
   assign prog_waddr_o  = waddr_p1;
   assign prog_wdata_o  = wdata_p1;
   assign tx_data_o     = tx_data_q;
   assign load_active_o = active_q;
   assign err_o         = err_q;

endmodule
